flash_loader: RTL and testbench
===============================

Name: flash_loader

Overview:
- Write-side companion to the program flash read port. Receives a byte stream (e.g. from the UART RX) and writes 16-bit instruction words into the program memory array.
- Holds the CPU off while loading, so the core fetches only a complete image.
- Sits between the host byte source and the program memory's write port. The memory's read port to the CPU is unchanged.

Parameters:
- flash_width, 10, program memory address width in words; capacity is 2**flash_width words.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a load session
- in_valid  input  1  byte source has data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts the byte this cycle
- wr_en  output  1  program memory write strobe
- wr_a  output  flash_width  write word address
- wr_d  output  16  write word data
- busy  output  1  session in progress; drives the CPU reset/hold
- done  output  1  level; last session completed without error
- error  output  1  level; last session aborted

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=0, wr_en=0, wr_a=0, wr_d=0, busy=0, done=0, error=0. Counters and the length register clear. Reset mid-session abandons it; words already written stay in memory.
- A byte is accepted only in a cycle where in_valid and in_ready are both 1.
- in_ready=1 in LEN_LO, LEN_HI, DAT_LO, DAT_HI and CHK; 0 in IDLE. It is combinational from state only, never from in_valid.
- Frame format: length N as 16-bit little-endian, then N words, each low byte then high byte.
- FSM states: IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, CHK (feature only).
- IDLE: on start, go to LEN_LO. On the same edge: clear done, error, word address and checksum; set busy.
- start is ignored when not in IDLE.
- LEN_LO: on accept, latch N[7:0]; go to LEN_HI.
- LEN_HI: on accept, latch N[15:8], then check the full N:
  - N > 2**flash_width: error=1, busy=0, go to IDLE. No writes occur.
  - N = 0: skip data (go to CHK if the feature is built, else finish).
  - Otherwise: go to DAT_LO.
- DAT_LO: on accept, latch the low byte; go to DAT_HI.
- DAT_HI: on accept, register wr_d={in_data, low byte} and wr_en=1 for exactly one cycle.
  - wr_en is registered, so the write strobe appears the cycle after the high-byte accept; wr_a holds the current word address during it.
  - wr_a increments the cycle after the strobe.
  - When the word count reaches N, finish (or go to CHK). Otherwise return to DAT_LO.
- Finish: busy=0 and done=1 on the same edge the last wr_en deasserts. busy therefore stays high through the final write.
- Word address is flash_width bits. The N limit guarantees it never wraps within a session.
- No timeout: a stalled source leaves busy high until rst_n.

Optional Feature:
- FLASH_LOADER_CHECKSUM_EN defined:
  - An 8-bit modulo-256 sum covers all accepted length and data bytes.
  - After the data, state CHK accepts one trailer byte.
  - Trailer equal to the sum: done=1. Otherwise: error=1. Either way busy=0 and state returns to IDLE.
  - Words already written are not rolled back.
- Not defined: no CHK state and no trailer byte; the session finishes directly after the last word (or after LEN_HI when N=0).

Decomposition:
- Shared package: state encoding constants, frame byte order constants, and the 16-bit word width constant.
- No sub-module needed; a single FSM plus counters.
- The memory write port is added to the program memory block, not duplicated here.

Test Plan:
- Stream after start: 0x02,0x00,0x0C,0x94,0x34,0x12 -> two wr_en pulses: (a=0, d=0x940C), then (a=1, d=0x1234); then done=1, busy=0, error=0.
- Same frame with in_valid toggling every other cycle -> identical writes; no byte is lost or duplicated; in_ready never depends on in_valid.
- With flash_width=10, length 0x01,0x04 (N=1025) -> error=1, busy=0, zero wr_en pulses; the next start clears error.
- Length 0x00,0x00 -> no writes; done=1 (with the feature, only after the trailer byte 0x00).
- FLASH_LOADER_CHECKSUM_EN, frame 0x01,0x00,0xAA,0x55: trailer 0x00 -> done=1; trailer 0x01 -> error=1 and the word 0x55AA is still written at a=0.
- rst_n low after the first data word -> all outputs 0 immediately (async); start issued mid-session -> ignored, wr_a sequence unchanged.

Source files
------------

// File: rtl/flash_loader_pkg.sv
// Shared constants for the program flash loader: FSM encoding, frame byte order, word width.
// Little-endian frames: low byte first, both for the length field and each data word.
package flash_loader_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;
    localparam int LO_LSB = 0;
    localparam int HI_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DAT_LO = 3'd3,
        ST_DAT_HI = 3'd4,
        ST_CHK    = 3'd5
    } state_t;

    function automatic logic [WORD_W-1:0] le_word(input logic [BYTE_W-1:0] lo,
                                                  input logic [BYTE_W-1:0] hi);
        le_word = '0;
        le_word[LO_LSB +: BYTE_W] = lo;
        le_word[HI_LSB +: BYTE_W] = hi;
    endfunction

endpackage

// File: rtl/flash_loader.sv
// Byte stream to 16-bit program memory writes; busy holds the CPU until the image is complete.
// Write strobe is registered (one cycle after the high byte); FLASH_LOADER_CHECKSUM_EN adds a trailer sum byte.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int flash_width = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [BYTE_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [flash_width-1:0] wr_a,
    output logic [WORD_W-1:0]      wr_d,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    state_t            state, state_nxt;
    logic [BYTE_W-1:0] len_lo, dat_lo;
    logic [WORD_W-1:0] len, cnt, len_full;
    logic              acc, go, len_bad, last_word;
`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
`else
    logic              fin_pend;
`endif

    assign in_ready  = (state != ST_IDLE);
    assign acc       = in_valid && in_ready;
    // busy lingers in IDLE for the final strobe cycle; a start then must not restart the session
    assign go        = start && !busy;
    assign len_full  = le_word(len_lo, in_data);
    assign len_bad   = 32'(len_full) > (32'd1 << flash_width);
    assign last_word = (cnt + WORD_W'(1)) == len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (go)  state_nxt = ST_LEN_LO;
            ST_LEN_LO: if (acc) state_nxt = ST_LEN_HI;
            ST_LEN_HI: if (acc) begin
                if (len_bad)
                    state_nxt = ST_IDLE;
                else if (len_full == '0)
`ifdef FLASH_LOADER_CHECKSUM_EN
                    state_nxt = ST_CHK;
`else
                    state_nxt = ST_IDLE;
`endif
                else
                    state_nxt = ST_DAT_LO;
            end
            ST_DAT_LO: if (acc) state_nxt = ST_DAT_HI;
            ST_DAT_HI: if (acc) begin
                if (last_word)
`ifdef FLASH_LOADER_CHECKSUM_EN
                    state_nxt = ST_CHK;
`else
                    state_nxt = ST_IDLE;
`endif
                else
                    state_nxt = ST_DAT_LO;
            end
`ifdef FLASH_LOADER_CHECKSUM_EN
            ST_CHK:    if (acc) state_nxt = ST_IDLE;
`endif
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en  <= 1'b0;
            wr_a   <= '0;
            wr_d   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            len_lo <= '0;
            dat_lo <= '0;
            len    <= '0;
            cnt    <= '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
            csum   <= '0;
`else
            fin_pend <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (wr_en) wr_a <= wr_a + 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
            if (acc && state != ST_CHK) csum <= csum + in_data;
`else
            // finish lands on the edge where the last strobe drops
            if (fin_pend) begin
                fin_pend <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
            end
`endif
            case (state)
                ST_IDLE: if (go) begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    busy  <= 1'b1;
                    wr_a  <= '0;
                    cnt   <= '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
                    csum  <= '0;
`endif
                end
                ST_LEN_LO: if (acc) len_lo <= in_data;
                ST_LEN_HI: if (acc) begin
                    len <= len_full;
                    if (len_bad) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end
`ifndef FLASH_LOADER_CHECKSUM_EN
                    else if (len_full == '0) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
`endif
                end
                ST_DAT_LO: if (acc) dat_lo <= in_data;
                ST_DAT_HI: if (acc) begin
                    wr_en <= 1'b1;
                    wr_d  <= le_word(dat_lo, in_data);
                    cnt   <= cnt + WORD_W'(1);
`ifndef FLASH_LOADER_CHECKSUM_EN
                    if (last_word) fin_pend <= 1'b1;
`endif
                end
`ifdef FLASH_LOADER_CHECKSUM_EN
                ST_CHK: if (acc) begin
                    busy <= 1'b0;
                    if (in_data == csum) done  <= 1'b1;
                    else                 error <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_loader.sv
// Self-checking bench for flash_loader: directed frame table, hand sequences and a queue-based random model.
module tb_flash_loader;

    localparam int FW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, wr_en, busy, done, error;
    logic [FW-1:0] wr_a;
    logic [15:0]   wr_d;

    int n_chk = 0;
    int n_pass = 0;
    logic [FW-1:0] wa_q[$];
    logic [15:0]   wd_q[$];
    logic          rdy_bad;

    typedef logic [7:0]  bq_t[$];
    typedef logic [15:0] wq_t[$];

    typedef struct {
        int          n;
        logic [47:0] raw;
        int          mode;
        bit          trl;
        int          nwr;
        logic [15:0] d0;
        logic [15:0] d1;
        bit          edone;
        bit          eerr;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    flash_loader #(.flash_width(FW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_a     (wr_a),
        .wr_d     (wr_d),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_a);
            wd_q.push_back(wr_d);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    endtask

    function automatic logic [7:0] sum8(input bq_t b);
        logic [7:0] s = 8'h00;
        foreach (b[i]) s = s + b[i];
        return s;
    endfunction

    // mode 0: always valid, 1: valid every other cycle, 2: random valid
    task automatic send(input bq_t b, input int mode, input int poke);
        bit tog = 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            int   guard = 0;
            bit   sent = 1'b0;
            logic v;
            if (i == poke) begin
                @(negedge clk);
                in_valid = 1'b0;
                start = 1'b1;
            end
            while (!sent && guard < 200) begin
                @(negedge clk);
                start = 1'b0;
                case (mode)
                    0:       v = 1'b1;
                    1:       begin v = tog; tog = ~tog; end
                    default: v = 1'($urandom_range(0, 1));
                endcase
                if (!v && !in_ready) rdy_bad = 1'b1;
                in_valid = v;
                in_data  = b[i];
                if (v && in_ready) sent = 1'b1;
                guard++;
            end
            if (!sent) begin
                n_chk++;
                $display("FAIL send_timeout: byte %0d not accepted, in_ready=%0b want 1", i, in_ready);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_frame(input string nm, input bq_t b, input int mode, input int poke,
                             input wq_t exp_w, input logic exp_done, input logic exp_err);
        int guard = 0;
        int m;
        wa_q.delete();
        wd_q.delete();
        rdy_bad = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "/start_flags"}, 32'({busy, done, error}), 32'(3'b100));
        send(b, mode, poke);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            n_chk++;
            $display("FAIL %s/busy_timeout: busy=1 want 0", nm);
        end
        repeat (2) @(negedge clk);
        chk({nm, "/nwr"},   32'(wd_q.size()), 32'(exp_w.size()));
        chk({nm, "/done"},  32'(done),  32'(exp_done));
        chk({nm, "/error"}, 32'(error), 32'(exp_err));
        chk({nm, "/busy"},  32'(busy),  32'h0);
        chk({nm, "/in_ready_indep"}, 32'(rdy_bad), 32'h0);
        m = (wd_q.size() < exp_w.size()) ? wd_q.size() : exp_w.size();
        for (int i = 0; i < m; i++) begin
            chk({nm, "/wr_a"}, 32'(wa_q[i]), 32'(i));
            chk({nm, "/wr_d"}, 32'(wd_q[i]), 32'(exp_w[i]));
        end
    endtask

    initial begin
        bq_t  b;
        wq_t  w;
        logic exp_done, exp_err;

        tbl[0] = '{6, 48'h02000C943412, 0, 1'b1, 2, 16'h940C, 16'h1234, 1'b1, 1'b0};
        tbl[1] = '{6, 48'h02000C943412, 1, 1'b1, 2, 16'h940C, 16'h1234, 1'b1, 1'b0};
        tbl[2] = '{2, 48'h000000000104, 0, 1'b0, 0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        tbl[3] = '{2, 48'h000000000000, 0, 1'b1, 0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[4] = '{4, 48'h00000100AA55, 2, 1'b1, 1, 16'h55AA, 16'h0000, 1'b1, 1'b0};

        #1 rst_n = 1'b0;
        #2;
        chk("reset_outputs", 32'({in_ready, wr_en, busy, done, error, wr_a, wr_d}), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            b.delete();
            w.delete();
            for (int i = 0; i < tbl[t].n; i++) b.push_back(tbl[t].raw[8*(tbl[t].n-1-i) +: 8]);
`ifdef FLASH_LOADER_CHECKSUM_EN
            if (tbl[t].trl) b.push_back(sum8(b));
`endif
            if (tbl[t].nwr > 0) w.push_back(tbl[t].d0);
            if (tbl[t].nwr > 1) w.push_back(tbl[t].d1);
            run_frame($sformatf("tbl%0d", t), b, tbl[t].mode, -1, w, tbl[t].edone, tbl[t].eerr);
        end

        // start pulse between the two data words must be ignored
        b = {8'h02, 8'h00, 8'h0C, 8'h94, 8'h34, 8'h12};
`ifdef FLASH_LOADER_CHECKSUM_EN
        b.push_back(sum8(b));
`endif
        w = {16'h940C, 16'h1234};
        run_frame("mid_start", b, 0, 4, w, 1'b1, 1'b0);

        // largest legal image fills the whole array
        b = {8'h00, 8'h04};
        w.delete();
        for (int i = 0; i < (1 << FW); i++) begin
            logic [15:0] x = 16'($urandom);
            w.push_back(x);
            b.push_back(x[7:0]);
            b.push_back(x[15:8]);
        end
`ifdef FLASH_LOADER_CHECKSUM_EN
        b.push_back(sum8(b));
`endif
        run_frame("full_image", b, 0, -1, w, 1'b1, 1'b0);

`ifdef FLASH_LOADER_CHECKSUM_EN
        b = {8'h01, 8'h00, 8'hAA, 8'h55, 8'h00};
        w = {16'h55AA};
        run_frame("ck_good", b, 0, -1, w, 1'b1, 1'b0);
        b = {8'h01, 8'h00, 8'hAA, 8'h55, 8'h01};
        run_frame("ck_bad", b, 0, -1, w, 1'b0, 1'b1);
`endif

        // random frames against a word-list model
        for (int r = 0; r < 10; r++) begin
            int n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1025, 1200))
                                                : int'($urandom_range(0, 6));
            b.delete();
            w.delete();
            b.push_back(8'(n));
            b.push_back(8'(n >> 8));
            exp_err  = (n > (1 << FW));
            exp_done = !exp_err;
            if (!exp_err) begin
                for (int i = 0; i < n; i++) begin
                    logic [15:0] x = 16'($urandom);
                    w.push_back(x);
                    b.push_back(x[7:0]);
                    b.push_back(x[15:8]);
                end
`ifdef FLASH_LOADER_CHECKSUM_EN
                begin
                    logic [7:0] s = sum8(b);
                    logic [7:0] tr = ($urandom_range(0, 2) == 0) ? (s ^ 8'h5A) : s;
                    b.push_back(tr);
                    exp_done = (tr == s);
                    exp_err  = (tr != s);
                end
`endif
            end
            run_frame($sformatf("rnd%0d", r), b, 2, -1, w, exp_done, exp_err);
        end

        // asynchronous reset in the middle of a session
        wa_q.delete();
        wd_q.delete();
        rdy_bad = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = {8'h02, 8'h00, 8'h0C, 8'h94};
        send(b, 0, -1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({in_ready, wr_en, busy, done, error, wr_a, wr_d}), 32'h0);
        chk("async_reset_nwr", 32'(wd_q.size()), 32'd1);
        #5 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", 32'({in_ready, busy, done, error}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
